// File: rtl/dspba_pipe_pkg.sv
// dspba_pipe_pkg: shared limits and count-width helper for the elastic delay line
package dspba_pipe_pkg;
  localparam int DSPBA_PIPE_MAX_DEPTH = 64;
  function automatic int cnt_width(input int depth);
    return ($clog2(depth + 1) > 1) ? $clog2(depth + 1) : 1;
  endfunction
endpackage

// File: rtl/dspba_pipe_stage.sv
// dspba_pipe_stage: one valid+data slice of the elastic delay line
module dspba_pipe_stage
  import dspba_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter bit RESET_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adv,
  input  logic             flush,
  input  logic             v_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             v,
  output logic [WIDTH-1:0] d
);
  // valid bit: flush empties the slice, otherwise it follows upstream whenever it advances
  always_ff @(posedge clk or negedge reset)
    if (!reset) v <= 1'b0;
    else if (flush) v <= 1'b0;
    else if (adv) v <= v_in;
  if (RESET_DATA) begin : g_rst
    // payload loads only when a real entry moves in, so bubbles never toggle it
    always_ff @(posedge clk or negedge reset)
      if (!reset) d <= '0;
      else if (adv && v_in && !flush) d <= d_in;
  end else begin : g_nrst
    // payload loads only when a real entry moves in; no reset on the data path
    always_ff @(posedge clk)
      if (adv && v_in && !flush) d <= d_in;
  end
endmodule

// File: rtl/dspba_pipe_delay.sv
// dspba_pipe_delay: elastic DEPTH-stage delay line with backpressure, bubble collapse and occupancy count; DSPBA_PIPE_FLUSH_EN adds a synchronous flush
module dspba_pipe_delay
  import dspba_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter bit RESET_DATA = 1'b1,
  localparam int CNTW = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
`ifdef DSPBA_PIPE_FLUSH_EN
  input  logic             flush,
`endif
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNTW-1:0]  count
);
  if (DEPTH < 0 || DEPTH > DSPBA_PIPE_MAX_DEPTH || WIDTH < 1) begin : g_bad_cfg
    $error("dspba_pipe_delay: DEPTH must be 0..%0d and WIDTH >= 1", DSPBA_PIPE_MAX_DEPTH);
  end
  if (DEPTH == 0) begin : g_wire
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready;
    assign count     = '0;
  end else begin : g_pipe
    logic [DEPTH-1:0] v, adv;
    logic [WIDTH-1:0] d [DEPTH];
    logic fl, in_hs, out_hs;
`ifdef DSPBA_PIPE_FLUSH_EN
    assign fl = flush;
`else
    assign fl = 1'b0;
`endif
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             vi;
      logic [WIDTH-1:0] di;
      if (i == 0) begin : g_head
        assign vi = in_valid;
        assign di = in_data;
      end else begin : g_body
        assign vi = v[i-1];
        assign di = d[i-1];
      end
      assign adv[i] = out_ready || !(&v[DEPTH-1:i]);
      dspba_pipe_stage #(.WIDTH(WIDTH), .RESET_DATA(RESET_DATA)) u_stage (
        .clk  (clk),
        .reset(reset),
        .adv  (adv[i]),
        .flush(fl),
        .v_in (vi),
        .d_in (di),
        .v    (v[i]),
        .d    (d[i])
      );
    end
    assign in_ready  = adv[0] && !fl;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    // occupancy: +1 per accepted input, -1 per delivered output, flush empties
    always_ff @(posedge clk or negedge reset)
      if (!reset) count <= '0;
      else if (fl) count <= '0;
      else count <= count + CNTW'(in_hs) - CNTW'(out_hs);
  end
endmodule
